read_buffer: RTL and testbench

- Read-side counterpart of the ADC sample circular buffer.
- On START, takes a frozen write pointer and a sample count. Streams the last NUM_SAMPLES samples from the buffer memory, oldest first, with address wrap-around.
- Output is a valid/ready stream toward the packetiser/host interface.
- Memory has a 1-cycle read latency. The block sustains 1 sample/cycle under continuous READY and never drops or duplicates a sample under backpressure.

---
 rtl/read_buffer_pkg.sv | 24 ++
 rtl/read_buffer_skid.sv | 70 +++++++
 rtl/read_buffer.sv | 208 ++++++++++++++++++++
 tb/tb_read_buffer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/read_buffer_pkg.sv
// Shared types and helpers for the circular-buffer readout engine.
// Optional build macro used by the readout top: READ_BUFFER_INDEX_EN.
package read_buffer_pkg;

    // Readout sequencing states.
    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDrain,
        StFinish
    } state_e;

    // Entries the output skid FIFO can hold. This also bounds the number of
    // reads in flight plus samples held.
    localparam int unsigned SkidDepth = 2;

    // Address increment that wraps explicitly at the buffer depth. This works for
    // depths that are not a power of two, without needing a modulo.
    function automatic int unsigned wrap_inc(input int unsigned addr,
                                             input int unsigned max_samples);
        return (addr == max_samples - 1) ? 0 : addr + 1;
    endfunction

endpackage

// File: rtl/read_buffer_skid.sv
// Two-entry fall-through valid/ready FIFO. When the FIFO is empty, incoming data
// bypasses straight to the output, so a sample can be consumed the same cycle it
// arrives. The producer only pushes when space is guaranteed.
module read_buffer_skid
    import read_buffer_pkg::*;
#(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    input  logic [Width-1:0] in_data_i,
    output logic             out_valid_o,
    output logic [Width-1:0] out_data_o,
    input  logic             out_ready_i,
    output logic [1:0]       count_o
);

    logic [Width-1:0] mem_q [SkidDepth];
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             wr_ptr;
    logic             empty;
    logic             push;
    logic             pop;

    // Head selection, bypass decision and occupancy bookkeeping.
    always_comb begin
        empty       = (count_q == 2'd0);
        out_valid_o = !empty || in_valid_i;
        if (!empty) begin
            out_data_o = mem_q[rd_ptr_q];
        end else if (in_valid_i) begin
            out_data_o = in_data_i;
        end else begin
            out_data_o = '0;
        end
        // Arriving data is stored unless it bypasses and is consumed immediately.
        push     = in_valid_i && !(empty && out_ready_i);
        pop      = out_ready_i && !empty;
        wr_ptr   = rd_ptr_q ^ count_q[0];
        rd_ptr_d = pop ? ~rd_ptr_q : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Storage and pointers; reset empties the FIFO.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            for (int i = 0; i < SkidDepth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) begin
                mem_q[wr_ptr] <= in_data_i;
            end
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/read_buffer.sv
// Readout engine for the ADC sample circular buffer. On START it streams the
// last n samples before the frozen write pointer, oldest first, using a valid/ready
// interface. Memory read latency is one cycle. Reads are throttled so that reads
// in flight plus samples held in the skid FIFO never exceed the FIFO depth.
// Optional build macro: READ_BUFFER_INDEX_EN adds the SAMPLE_IDX output.
module read_buffer
    import read_buffer_pkg::*;
#(
    parameter int unsigned MAX_SAMPLES = 16,
    parameter int unsigned ADDR_BITS   = $clog2(MAX_SAMPLES),
    parameter int unsigned DWIDTH      = 14
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic                 START,
    input  logic [ADDR_BITS-1:0] WR_PTR,
    input  logic [ADDR_BITS:0]   NUM_SAMPLES,
    output logic                 MEM_RD_EN,
    output logic [ADDR_BITS-1:0] MEM_ADDR,
    input  logic [DWIDTH-1:0]    MEM_DATA,
    output logic [DWIDTH-1:0]    DATA_OUT,
    output logic                 VALID,
    input  logic                 READY,
    output logic                 LAST,
    output logic                 BUSY,
    output logic                 DONE
`ifdef READ_BUFFER_INDEX_EN
    ,
    output logic [ADDR_BITS-1:0] SAMPLE_IDX
`endif
);

    localparam int unsigned CntW = ADDR_BITS + 1;
    localparam int unsigned SumW = ADDR_BITS + 2;
`ifdef READ_BUFFER_INDEX_EN
    localparam int unsigned PayW = 1 + ADDR_BITS + DWIDTH;
`else
    localparam int unsigned PayW = 1 + DWIDTH;
`endif

    state_e               state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [CntW-1:0]      rd_left_q, rd_left_d;
    logic [CntW-1:0]      out_left_q, out_left_d;
    logic                 pend_q, pend_d;
    logic                 pend_last_q, pend_last_d;
`ifdef READ_BUFFER_INDEX_EN
    logic [ADDR_BITS-1:0] issue_idx_q, issue_idx_d;
    logic [ADDR_BITS-1:0] pend_idx_q, pend_idx_d;
`endif

    logic [CntW-1:0]      n_clamp;
    logic [SumW-1:0]      start_sum;
    logic [ADDR_BITS-1:0] start_addr;
    logic                 issue;
    logic                 accept;
    logic                 skid_valid;
    logic [1:0]           skid_count;
    logic [PayW-1:0]      skid_in;
    logic [PayW-1:0]      skid_out;

    // Clamp the requested count and locate the oldest requested sample.
    always_comb begin
        n_clamp = (NUM_SAMPLES > CntW'(MAX_SAMPLES)) ? CntW'(MAX_SAMPLES) : NUM_SAMPLES;
        start_sum = SumW'(WR_PTR) + SumW'(MAX_SAMPLES) - SumW'(n_clamp);
        if (start_sum >= SumW'(MAX_SAMPLES)) begin
            start_addr = ADDR_BITS'(start_sum - SumW'(MAX_SAMPLES));
        end else begin
            start_addr = ADDR_BITS'(start_sum);
        end
    end

    // A read may issue only when the returning sample is certain to find FIFO space.
    always_comb begin
        issue  = (state_q == StFetch) && ((32'(pend_q) + 32'(skid_count)) < SkidDepth);
        accept = skid_valid && READY;
    end

    // State register.
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (START) begin
                    state_d = (n_clamp == '0) ? StFinish : StFetch;
                end
            end
            StFetch: begin
                if (issue && (rd_left_q == CntW'(1))) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (accept && (out_left_q == CntW'(1))) begin
                    state_d = StFinish;
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // State-decoded outputs. BUSY is already low in the DONE cycle.
    always_comb begin
        BUSY      = (state_q == StFetch) || (state_q == StDrain);
        DONE      = (state_q == StFinish);
        MEM_RD_EN = issue;
        MEM_ADDR  = issue ? addr_q : '0;
    end

    // Datapath next state: address walk, read/accept countdowns, in-flight tag.
    always_comb begin
        addr_d      = addr_q;
        rd_left_d   = rd_left_q;
        out_left_d  = out_left_q;
        pend_d      = issue;
        pend_last_d = issue && (rd_left_q == CntW'(1));
`ifdef READ_BUFFER_INDEX_EN
        issue_idx_d = issue_idx_q;
        pend_idx_d  = issue_idx_q;
`endif
        if ((state_q == StIdle) && START && (n_clamp != '0)) begin
            addr_d     = start_addr;
            rd_left_d  = n_clamp;
            out_left_d = n_clamp;
`ifdef READ_BUFFER_INDEX_EN
            issue_idx_d = '0;
`endif
        end
        if (issue) begin
            addr_d    = ADDR_BITS'(wrap_inc(32'(addr_q), MAX_SAMPLES));
            rd_left_d = rd_left_q - CntW'(1);
`ifdef READ_BUFFER_INDEX_EN
            issue_idx_d = issue_idx_q + ADDR_BITS'(1);
`endif
        end
        if (accept && (out_left_q != '0)) begin
            out_left_d = out_left_q - CntW'(1);
        end
    end

    // Datapath registers; reset clears all pointers, counters and in-flight tags.
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            addr_q      <= '0;
            rd_left_q   <= '0;
            out_left_q  <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
`ifdef READ_BUFFER_INDEX_EN
            issue_idx_q <= '0;
            pend_idx_q  <= '0;
`endif
        end else begin
            addr_q      <= addr_d;
            rd_left_q   <= rd_left_d;
            out_left_q  <= out_left_d;
            pend_q      <= pend_d;
            pend_last_q <= pend_last_d;
`ifdef READ_BUFFER_INDEX_EN
            issue_idx_q <= issue_idx_d;
            pend_idx_q  <= pend_idx_d;
`endif
        end
    end

    // Returning sample with its sideband tags, packed for the skid FIFO.
    always_comb begin
`ifdef READ_BUFFER_INDEX_EN
        skid_in = {pend_last_q, pend_idx_q, MEM_DATA};
`else
        skid_in = {pend_last_q, MEM_DATA};
`endif
    end

    read_buffer_skid #(
        .Width (PayW)
    ) u_skid (
        .clk_i       (CLOCK),
        .rst_ni      (RESET),
        .in_valid_i  (pend_q),
        .in_data_i   (skid_in),
        .out_valid_o (skid_valid),
        .out_data_o  (skid_out),
        .out_ready_i (READY),
        .count_o     (skid_count)
    );

    // Unpack the FIFO head onto the stream. Fields read zero when the FIFO is empty.
    always_comb begin
        VALID    = skid_valid;
        DATA_OUT = skid_out[DWIDTH-1:0];
        LAST     = skid_out[PayW-1];
`ifdef READ_BUFFER_INDEX_EN
        SAMPLE_IDX = skid_out[DWIDTH +: ADDR_BITS];
`endif
    end

endmodule

// File: tb/tb_read_buffer.sv
// Self-checking bench for read_buffer. Expected streams come from the buffer
// contents and the "last n before write pointer" rule.
module tb_read_buffer;

    localparam int unsigned MaxA = 16;
    localparam int unsigned AbA  = 4;
    localparam int unsigned MaxB = 12;
    localparam int unsigned AbB  = 4;
    localparam int unsigned Dw   = 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic           start_a, rd_en_a, valid_a, ready_a, last_a, busy_a, done_a;
    logic [AbA-1:0] wr_ptr_a, addr_a;
    logic [AbA:0]   num_a;
    logic [Dw-1:0]  mem_data_a, data_out_a;

    logic           start_b, rd_en_b, valid_b, ready_b, last_b, busy_b, done_b;
    logic [AbB-1:0] wr_ptr_b, addr_b;
    logic [AbB:0]   num_b;
    logic [Dw-1:0]  mem_data_b, data_out_b;

`ifdef READ_BUFFER_INDEX_EN
    logic [AbA-1:0] idx_a;
    logic [AbB-1:0] idx_b;
`endif

    int checks   = 0;
    int failures = 0;

    logic [Dw-1:0] mem_a [MaxA];
    logic [Dw-1:0] mem_b [MaxB];

    always @(posedge clk) if (rd_en_a) mem_data_a <= mem_a[addr_a];
    always @(posedge clk) if (rd_en_b) mem_data_b <= mem_b[addr_b];

    read_buffer #(.MAX_SAMPLES(MaxA), .DWIDTH(Dw)) dut_a (
        .CLOCK(clk), .RESET(rst_n), .START(start_a), .WR_PTR(wr_ptr_a),
        .NUM_SAMPLES(num_a), .MEM_RD_EN(rd_en_a), .MEM_ADDR(addr_a),
        .MEM_DATA(mem_data_a), .DATA_OUT(data_out_a), .VALID(valid_a),
        .READY(ready_a), .LAST(last_a), .BUSY(busy_a), .DONE(done_a)
`ifdef READ_BUFFER_INDEX_EN
        , .SAMPLE_IDX(idx_a)
`endif
    );

    read_buffer #(.MAX_SAMPLES(MaxB), .DWIDTH(Dw)) dut_b (
        .CLOCK(clk), .RESET(rst_n), .START(start_b), .WR_PTR(wr_ptr_b),
        .NUM_SAMPLES(num_b), .MEM_RD_EN(rd_en_b), .MEM_ADDR(addr_b),
        .MEM_DATA(mem_data_b), .DATA_OUT(data_out_b), .VALID(valid_b),
        .READY(ready_b), .LAST(last_b), .BUSY(busy_b), .DONE(done_b)
`ifdef READ_BUFFER_INDEX_EN
        , .SAMPLE_IDX(idx_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One readout on the depth-16 instance. rdy_pct sets the READY probability.
    // abort_after>0 resets once that many samples are accepted.
    // restart_at>0 pulses a stray START on that cycle.
    task automatic run_readout(input int wp, input int ns, input int rdy_pct,
                               input int abort_after, input int restart_at);
        int            n, sa, k, issued, last_c;
        bit            hold, finished, aborted;
        logic [Dw-1:0] held_data;
        logic          held_last;
        logic [Dw-1:0] exp_q [$];
        n  = (ns > int'(MaxA)) ? int'(MaxA) : ns;
        sa = (wp + int'(MaxA) - n) % int'(MaxA);
        for (int i = 0; i < n; i++) exp_q.push_back(mem_a[(sa + i) % int'(MaxA)]);
        k = 0; issued = 0; last_c = (n == 0) ? 0 : -1;
        hold = 0; finished = 0; aborted = 0; held_data = '0; held_last = 0;
        start_a = 1'b1; wr_ptr_a = AbA'(wp); num_a = 5'(ns); ready_a = 1'b1;
        check("idle_valid_low", valid_a, 0);
        check("idle_busy_low", busy_a, 0);
        tick();
        start_a = 1'b0;
        for (int c = 1; c <= 400 && !finished && !aborted; c++) begin
            ready_a = ($urandom_range(99) < rdy_pct);
            if (c == restart_at) begin
                start_a = 1'b1; wr_ptr_a = AbA'(wp + 5); num_a = 5'd3;
            end else begin
                start_a = 1'b0;
            end
            if (rd_en_a) begin
                check("mem_addr", addr_a, (sa + issued) % int'(MaxA));
                if (rdy_pct == 100 && issued == 0) check("first_read_latency", c, 1);
                issued++;
                check("outstanding_le_2", (issued - k) <= 2, 1);
                check("reads_le_n", issued <= n, 1);
            end
            if (hold) begin
                check("hold_valid", valid_a, 1);
                check("hold_data", data_out_a, held_data);
                check("hold_last", last_a, held_last);
            end
            if (valid_a && k >= n) begin
                check("spurious_valid", valid_a, 0);
            end else if (valid_a && ready_a) begin
                check("data", data_out_a, exp_q[k]);
                check("last", last_a, k == n - 1);
`ifdef READ_BUFFER_INDEX_EN
                check("sample_idx", idx_a, k);
`endif
                if (rdy_pct == 100) check("throughput", c, k + 2);
                k++;
                if (k == n) last_c = c;
            end
            hold      = valid_a && !ready_a;
            held_data = data_out_a;
            held_last = last_a;
            if (last_c >= 0 && c == last_c + 1) begin
                check("done", done_a, 1);
                check("busy_low_at_done", busy_a, 0);
                finished = 1;
            end else begin
                check("no_early_done", done_a, 0);
            end
            if (abort_after > 0 && k == abort_after) aborted = 1;
            tick();
        end
        if (aborted) begin
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
            check("abort_valid_low", valid_a, 0);
            check("abort_busy_low", busy_a, 0);
            check("abort_no_done", done_a, 0);
            for (int i = 0; i < 4; i++) begin
                tick();
                check("post_abort_no_done", done_a, 0);
                check("post_abort_no_valid", valid_a, 0);
            end
        end else if (finished) begin
            check("done_one_cycle", done_a, 0);
        end else begin
            check("timeout", finished, 1);
        end
    endtask

    initial begin
        int  sb, kb, ib;
        bit  done_b_seen;
        rst_n = 1'b0;
        start_a = 0; wr_ptr_a = '0; num_a = '0; ready_a = 1;
        start_b = 0; wr_ptr_b = '0; num_b = '0; ready_b = 1;
        for (int i = 0; i < int'(MaxA); i++) mem_a[i] = Dw'(i);
        for (int i = 0; i < int'(MaxB); i++) mem_b[i] = Dw'(100 + i);
        tick();
        tick();
        check("rst_valid", valid_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_rd_en", rd_en_a, 0);
        check("rst_addr", addr_a, 0);
        check("rst_data", data_out_a, 0);
        check("rst_last", last_a, 0);
        rst_n = 1'b1;
        tick();

        run_readout(10, 4, 100, 0, 0);   // basic: 6..9
        run_readout(2, 5, 100, 0, 0);    // wrap: 13,14,15,0,1
        run_readout(7, 16, 100, 0, 0);   // full buffer
        run_readout(7, 20, 100, 0, 0);   // clamped to 16
        run_readout(10, 4, 50, 0, 0);    // backpressure
        run_readout(5, 0, 100, 0, 0);    // zero count
        run_readout(3, 10, 100, 0, 3);   // stray START ignored
        run_readout(12, 8, 100, 2, 0);   // reset after 2 samples
        run_readout(4, 8, 100, 0, 0);    // clean readout after abort

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < int'(MaxA); i++) mem_a[i] = Dw'($urandom);
            run_readout(int'($urandom_range(MaxA - 1)), int'($urandom_range(20)), 50, 0, 0);
        end

        // Non-power-of-two depth: 12 entries, WR_PTR=1, 3 samples.
        sb = (1 + int'(MaxB) - 3) % int'(MaxB);
        start_b = 1'b1; wr_ptr_b = 4'd1; num_b = 5'd3; ready_b = 1'b1;
        tick();
        start_b = 1'b0;
        kb = 0; ib = 0; done_b_seen = 0;
        for (int c = 1; c <= 30 && !done_b_seen; c++) begin
            if (rd_en_b) begin
                check("b_addr", addr_b, (sb + ib) % int'(MaxB));
                ib++;
            end
            if (valid_b) begin
                check("b_data", data_out_b, 100 + (sb + kb) % int'(MaxB));
                check("b_last", last_b, kb == 2);
                kb++;
            end
            if (done_b) begin
                done_b_seen = 1;
                check("b_count", kb, 3);
            end
            tick();
        end
        check("b_done_seen", done_b_seen, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
